// File: rtl/color_batch_spi_tx.sv
// color_batch_spi_tx
// Consumer end of the color batch path. A packed batch of BATCH_SIZE 8-bit
// colors is captured into a one-deep holding register and then serialized as
// a single SPI mode-0 transaction (MSB first, color 0 first) toward the
// matrix controller. The holding register lets a batch arrive while the
// previous one is still shifting out.

module color_batch_spi_tx #(
    parameter int unsigned BATCH_SIZE = 8,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned CS_GAP     = 4
) (
    input  logic                      I_rgb_clk,
    input  logic                      I_rst,
    input  logic                      I_batch_valid,
    input  logic [8*BATCH_SIZE-1:0]   I_batch_color,
    output logic                      O_batch_ready,
    output logic                      O_batch_drop,
    output logic                      O_spi_sck,
    output logic                      O_spi_mosi,
    output logic                      O_spi_cs_n,
    output logic                      O_busy,
    output logic                      O_batch_done
);

    localparam int unsigned NBITS = 8 * BATCH_SIZE;
    localparam int unsigned BIT_W = $clog2(NBITS) + 1;
    localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
    localparam int unsigned GAP_W = $clog2(CS_GAP + 1) + 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_GAP > 0) ? (CS_GAP - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TAIL,
        GAP
    } state_e;

    state_e             state_q, state_d;

    logic [NBITS-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic               ready_q, ready_d;
    logic               drop_q, drop_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic               cs_n_q, cs_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    logic               div_wrap;
    logic               bit_last;
    logic [2:0]         nxt_bit;
    logic [NBITS-1:0]   shift_nxt;

    assign accept    = I_batch_valid && ready_q;
    assign div_wrap  = (div_cnt_q == DIV_LAST);
    assign bit_last  = (bit_cnt_q == BIT_LAST);
    assign nxt_bit   = bit_cnt_q[2:0] + 3'd1;
    assign shift_nxt = shift_q >> 8;

    // State register with synchronous reset back to IDLE.
    always_ff @(posedge I_rgb_clk) begin
        if (I_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: SHIFT ends on the falling SCK edge of the last bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_wrap && sck_q && bit_last) begin
                    state_d = TAIL;
                end
            end
            TAIL: begin
                if (div_wrap) begin
                    state_d = (CS_GAP == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath next values; every output is taken from a register.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    cs_n_d      = 1'b0;
                    mosi_d      = hold_q[7];
                    div_cnt_d   = '0;
                    bit_cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (div_wrap) begin
                    div_cnt_d = '0;
                    if (sck_q) begin
                        // Falling edge: present the next bit, or finish.
                        sck_d = 1'b0;
                        if (bit_last) begin
                            mosi_d = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            if (nxt_bit == 3'd0) begin
                                // Byte boundary: drop the sent color, next one's MSB.
                                shift_d = shift_nxt;
                                mosi_d  = shift_nxt[7];
                            end else begin
                                mosi_d = shift_q[3'd7 - nxt_bit];
                            end
                        end
                    end else begin
                        sck_d = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            TAIL: begin
                sck_d = 1'b0;
                if (div_wrap) begin
                    div_cnt_d = '0;
                    cs_n_d    = 1'b1;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            GAP: begin
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
                if (gap_cnt_q != GAP_LAST) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
            end
        endcase

        // Accept only into an empty holding register; ready_q mirrors that.
        if (accept) begin
            hold_d      = I_batch_color;
            hold_full_d = 1'b1;
        end

        ready_d = !hold_full_d;
        drop_d  = I_batch_valid && !ready_q;
        busy_d  = (state_d != IDLE) || hold_full_d;
    end

    // Datapath and output registers; reset abandons any batch in flight.
    always_ff @(posedge I_rgb_clk) begin
        if (I_rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            ready_q     <= 1'b1;
            drop_q      <= 1'b0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            ready_q     <= ready_d;
            drop_q      <= drop_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign O_batch_ready = ready_q;
    assign O_batch_drop  = drop_q;
    assign O_spi_sck     = sck_q;
    assign O_spi_mosi    = mosi_q;
    assign O_spi_cs_n    = cs_n_q;
    assign O_busy        = busy_q;
    assign O_batch_done  = done_q;

endmodule

// File: tb/tb_color_batch_spi_tx.sv
// Testbench for color_batch_spi_tx: two instances (default parameters and a
// small fast configuration), an SPI-side monitor that decodes transactions,
// and directed plus randomized batches compared against expected streams.

module tb_color_batch_spi_tx;

    localparam int B_A = 8, CD_A = 2, GAP_A = 4;
    localparam int B_B = 2, CD_B = 1, GAP_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic                 va;
    logic [8*B_A-1:0]     ca;
    logic ready_a, drop_a, sck_a, mosi_a, csn_a, busy_a, done_a;

    logic                 vb;
    logic [8*B_B-1:0]     cb;
    logic ready_b, drop_b, sck_b, mosi_b, csn_b, busy_b, done_b;

    color_batch_spi_tx #(.BATCH_SIZE(B_A), .CLK_DIV(CD_A), .CS_GAP(GAP_A)) dut_a (
        .I_rgb_clk(clk), .I_rst(rst), .I_batch_valid(va), .I_batch_color(ca),
        .O_batch_ready(ready_a), .O_batch_drop(drop_a), .O_spi_sck(sck_a),
        .O_spi_mosi(mosi_a), .O_spi_cs_n(csn_a), .O_busy(busy_a), .O_batch_done(done_a)
    );

    color_batch_spi_tx #(.BATCH_SIZE(B_B), .CLK_DIV(CD_B), .CS_GAP(GAP_B)) dut_b (
        .I_rgb_clk(clk), .I_rst(rst), .I_batch_valid(vb), .I_batch_color(cb),
        .O_batch_ready(ready_b), .O_batch_drop(drop_b), .O_spi_sck(sck_b),
        .O_spi_mosi(mosi_b), .O_spi_cs_n(csn_b), .O_busy(busy_b), .O_batch_done(done_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected serial stream: color 0 first, each color MSB first.
    function automatic logic [63:0] stream(input logic [63:0] colors, input int nb);
        logic [63:0] s = '0;
        for (int i = 0; i < nb; i++) begin
            s = (s << 8) | ((colors >> (8 * i)) & 64'hFF);
        end
        return s;
    endfunction

    typedef struct {
        int          dut;
        logic [63:0] data;
        int          len;
        int          rises;
        int          gap;
        bit          done;
        int          first_rise;
        int          last_rise;
        int          hi_pref;
        int          hi_tot;
    } rec_t;

    rec_t rq[$];

    bit          mon_en = 1'b0;
    int          cyc = 0;
    int          low_len[2], rises[2], first_r[2], last_r[2], hi_pref[2], hi_tot[2];
    int          gap_st[2], drops[2], stray_done[2];
    int          high_len[2] = '{1000, 1000};
    bit          seen_low[2];
    bit          prev_cs[2] = '{1'b1, 1'b1};
    bit          prev_sck[2];
    logic [63:0] bits[2];

    // SPI-side monitor: decodes each cs_n-low window of both instances.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                logic cs, sck, mosi, dn, dp;
                rec_t r;
                cs   = (d == 0) ? csn_a  : csn_b;
                sck  = (d == 0) ? sck_a  : sck_b;
                mosi = (d == 0) ? mosi_a : mosi_b;
                dn   = (d == 0) ? done_a : done_b;
                dp   = (d == 0) ? drop_a : drop_b;
                if (cs === 1'b0) begin
                    if (prev_cs[d]) begin
                        gap_st[d]   = high_len[d];
                        low_len[d]  = 0;
                        rises[d]    = 0;
                        bits[d]     = '0;
                        first_r[d]  = -1;
                        last_r[d]   = -1;
                        hi_pref[d]  = 0;
                        hi_tot[d]   = 0;
                        seen_low[d] = 1'b0;
                    end
                    low_len[d]++;
                    if (mosi === 1'b1) begin
                        hi_tot[d]++;
                        if (!seen_low[d]) hi_pref[d]++;
                    end else begin
                        seen_low[d] = 1'b1;
                    end
                    if (!prev_sck[d] && sck === 1'b1) begin
                        rises[d]++;
                        bits[d] = {bits[d][62:0], mosi};
                        if (first_r[d] < 0) first_r[d] = cyc;
                        last_r[d] = cyc;
                    end
                end else begin
                    if (!prev_cs[d]) begin
                        r.dut = d; r.data = bits[d]; r.len = low_len[d]; r.rises = rises[d];
                        r.gap = gap_st[d]; r.done = dn; r.first_rise = first_r[d];
                        r.last_rise = last_r[d]; r.hi_pref = hi_pref[d]; r.hi_tot = hi_tot[d];
                        rq.push_back(r);
                        high_len[d] = 1;
                    end else begin
                        high_len[d]++;
                    end
                end
                if (dn === 1'b1 && !(cs === 1'b1 && !prev_cs[d])) stray_done[d]++;
                if (dp === 1'b1) drops[d]++;
                prev_cs[d]  = (cs !== 1'b0);
                prev_sck[d] = (sck === 1'b1);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic offer_a(input logic [63:0] c, input bit exp_ready, input string tag);
        step();
        check_eq({tag, "/ready_at_offer"}, ready_a, exp_ready);
        va = 1'b1;
        ca = c;
        step();
        va = 1'b0;
    endtask

    task automatic offer_b(input logic [15:0] c, input bit exp_ready, input string tag);
        step();
        check_eq({tag, "/ready_at_offer"}, ready_b, exp_ready);
        vb = 1'b1;
        cb = c;
        step();
        vb = 1'b0;
    endtask

    task automatic get_rec(input string tag, output rec_t r, output bit ok);
        int n = 0;
        while (rq.size() == 0 && n < 3000) begin
            step();
            n++;
        end
        ok = (rq.size() > 0);
        check_eq({tag, "/arrive"}, ok, 1);
        if (ok) r = rq.pop_front();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t        r;
        bit          ok;
        logic [63:0] c, p, q;
        int          n, d0;
        localparam int LEN_A = 16 * B_A * CD_A + CD_A;
        localparam int LEN_B = 16 * B_B * CD_B + CD_B;

        rst = 1'b1; va = 1'b0; ca = '0; vb = 1'b0; cb = '0;
        step(3);
        check_eq("rst/cs_n", {csn_a, csn_b}, 2'b11);
        check_eq("rst/sck", {sck_a, sck_b}, 2'b00);
        check_eq("rst/mosi", {mosi_a, mosi_b}, 2'b00);
        check_eq("rst/ready", {ready_a, ready_b}, 2'b11);
        check_eq("rst/busy_drop_done", {busy_a, drop_a, done_a, busy_b, drop_b, done_b}, 6'b0);
        rst = 1'b0;
        mon_en = 1'b1;
        step(3);

        // Single batch of colors 01..08.
        offer_a(64'h0807060504030201, 1'b1, "t1");
        get_rec("t1", r, ok);
        if (ok) begin
            check_eq("t1/data", r.data, 64'h0102030405060708);
            check_eq("t1/cs_low_len", r.len, LEN_A);
            check_eq("t1/sck_rises", r.rises, 64);
            check_eq("t1/done_with_cs_rise", r.done, 1);
        end

        // Acceptance latency from idle.
        step(10);
        c = {$urandom, $urandom};
        offer_a(c, 1'b1, "t2");
        check_eq("t2/ready_t1", ready_a, 0);
        check_eq("t2/cs_n_t1", csn_a, 1);
        check_eq("t2/busy_t1", busy_a, 1);
        step();
        check_eq("t2/ready_t2", ready_a, 1);
        check_eq("t2/cs_n_t2", csn_a, 0);
        check_eq("t2/sck_t2", sck_a, 0);
        check_eq("t2/mosi_first", mosi_a, c[7]);
        for (int k = 1; k < CD_A; k++) begin
            step();
            check_eq("t2/sck_low_phase", sck_a, 0);
        end
        step();
        check_eq("t2/first_sck_rise", sck_a, 1);
        get_rec("t2", r, ok);
        if (ok) check_eq("t2/data", r.data, stream(c, B_A));

        // Back-to-back with a dropped third batch.
        step(10);
        d0 = drops[0];
        p = {$urandom, $urandom};
        offer_a(p, 1'b1, "t3p");
        step($urandom_range(5, 200));
        offer_a({8{8'hA5}}, 1'b1, "t3q");
        check_eq("t3/ready_hold_full", ready_a, 0);
        step(2);
        q = {$urandom, $urandom};
        offer_a(q, 1'b0, "t3c");
        check_eq("t3/drop_pulse", drop_a, 1);
        step();
        check_eq("t3/drop_one_cycle", drop_a, 0);
        get_rec("t3p", r, ok);
        if (ok) check_eq("t3/first_data", r.data, stream(p, B_A));
        get_rec("t3q", r, ok);
        if (ok) begin
            check_eq("t3/second_data", r.data, 64'hA5A5A5A5A5A5A5A5);
            check_eq("t3/cs_high_gap", r.gap, GAP_A + 1);
            check_eq("t3/second_len", r.len, LEN_A);
        end
        step(400);
        check_eq("t3/no_third_tx", rq.size(), 0);
        check_eq("t3/drop_count", drops[0] - d0, 1);
        check_eq("t3/idle_after", {csn_a, busy_a}, 2'b10);

        // Randomized back-to-back pairs.
        for (int it = 0; it < 3; it++) begin
            step(10);
            p = {$urandom, $urandom};
            q = {$urandom, $urandom};
            offer_a(p, 1'b1, "rnd_p");
            step($urandom_range(5, 250));
            offer_a(q, 1'b1, "rnd_q");
            get_rec("rnd_p", r, ok);
            if (ok) check_eq("rnd/p_data", r.data, stream(p, B_A));
            get_rec("rnd_q", r, ok);
            if (ok) begin
                check_eq("rnd/q_data", r.data, stream(q, B_A));
                check_eq("rnd/q_gap", r.gap, GAP_A + 1);
                check_eq("rnd/q_len", r.len, LEN_A);
            end
        end

        // Reset mid-SHIFT with a batch waiting in the holding register.
        step(10);
        offer_a({$urandom, $urandom}, 1'b1, "t4x");
        step();
        offer_a({$urandom, $urandom}, 1'b1, "t4h");
        n = 0;
        while (rises[0] != 20 && n < 2000) begin
            step();
            n++;
        end
        check_eq("t4/reached_20_bits", rises[0], 20);
        rst = 1'b1;
        step();
        check_eq("t4/cs_n", csn_a, 1);
        check_eq("t4/sck", sck_a, 0);
        check_eq("t4/mosi", mosi_a, 0);
        check_eq("t4/ready", ready_a, 1);
        check_eq("t4/busy_done_drop", {busy_a, done_a, drop_a}, 3'b000);
        rst = 1'b0;
        get_rec("t4_partial", r, ok);
        if (ok) begin
            check_eq("t4/partial_no_done", r.done, 0);
            check_eq("t4/partial_bits", r.rises, 20);
        end
        step(60);
        check_eq("t4/hold_discarded", rq.size(), 0);
        check_eq("t4/idle", {csn_a, busy_a}, 2'b10);
        c = {$urandom, $urandom};
        offer_a(c, 1'b1, "t4y");
        get_rec("t4y", r, ok);
        if (ok) begin
            check_eq("t4/after_data", r.data, stream(c, B_A));
            check_eq("t4/after_len", r.len, LEN_A);
            check_eq("t4/after_done", r.done, 1);
        end

        // Small fast configuration.
        step(10);
        offer_b(16'h00FF, 1'b1, "t5");
        get_rec("t5", r, ok);
        if (ok) begin
            check_eq("t5/dut", r.dut, 1);
            check_eq("t5/data", r.data, 64'hFF00);
            check_eq("t5/cs_low_len", r.len, LEN_B);
            check_eq("t5/sck_rises", r.rises, 16);
            check_eq("t5/sck_period", r.last_rise - r.first_rise, 2 * 15);
            check_eq("t5/mosi_high_prefix", r.hi_pref, 16);
            check_eq("t5/mosi_high_total", r.hi_tot, 16);
            check_eq("t5/done", r.done, 1);
        end
        step(5);
        p = {32'd0, $urandom};
        q = {32'd0, $urandom};
        offer_b(p[15:0], 1'b1, "t5p");
        step(3);
        offer_b(q[15:0], 1'b1, "t5q");
        get_rec("t5p", r, ok);
        if (ok) check_eq("t5/p_data", r.data, stream(p, B_B));
        get_rec("t5q", r, ok);
        if (ok) begin
            check_eq("t5/q_data", r.data, stream(q, B_B));
            check_eq("t5/q_gap", r.gap, GAP_B + 1);
        end

        step(20);
        check_eq("end/stray_done_a", stray_done[0], 0);
        check_eq("end/stray_done_b", stray_done[1], 0);
        check_eq("end/drops_b", drops[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
